// File: rtl/regs_system_seq.sv
// System configuration register fan-out with break-before-make switch sequencing,
// atomic config update, and a one-deep queue for commits arriving while busy.
module regs_system_seq #(
    parameter int unsigned      NUM_SW        = 24,
    parameter int unsigned      CFG_W         = 35,
    parameter logic [CFG_W-1:0] CFG_RESET     = '0,
    parameter int unsigned      DEAD_CYCLES   = 4,
    parameter int unsigned      SETTLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] bus_sw,
    input  logic [CFG_W-1:0]  bus_cfg,
    input  logic              bus_commit,
    input  logic              bus_seq_en,
    output logic              bus_busy,
    output logic              bus_pending,
    output logic              bus_done,
    output logic [NUM_SW-1:0] bus_sw_rb,
    input  logic              mgmt_select,
    output logic              bus_mgmt_select,
    output logic [NUM_SW-1:0] sw_out,
    output logic [CFG_W-1:0]  cfg_out
);

    typedef enum logic [1:0] {IDLE, DEAD, SETTLE} state_t;

    localparam logic [7:0] DEAD_LD   = 8'(DEAD_CYCLES);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

    state_t            state, state_next;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_SW-1:0] sw_q, sw_d, tgt_sw_q, tgt_sw_d, pend_sw_q, pend_sw_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d, tgt_cfg_q, tgt_cfg_d, pend_cfg_q, pend_cfg_d;
    logic              pend_q, pend_d, done_q, done_d, busy_q, mgmt_q;

    logic              start, cnt_last;
    logic [NUM_SW-1:0] src_sw;
    logic [CFG_W-1:0]  src_cfg;

    // A fresh commit takes priority over the queued one.
    assign start    = bus_commit | pend_q;
    assign src_sw   = bus_commit ? bus_sw  : pend_sw_q;
    assign src_cfg  = bus_commit ? bus_cfg : pend_cfg_q;
    assign cnt_last = (cnt_q == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && bus_seq_en) state_next = DEAD;
            DEAD:    if (cnt_last) state_next = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
            SETTLE:  if (cnt_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        sw_d       = sw_q;
        cfg_d      = cfg_q;
        tgt_sw_d   = tgt_sw_q;
        tgt_cfg_d  = tgt_cfg_q;
        pend_d     = pend_q;
        pend_sw_d  = pend_sw_q;
        pend_cfg_d = pend_cfg_q;
        done_d     = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                pend_d = 1'b0;
                if (bus_seq_en) begin
                    tgt_sw_d  = src_sw;
                    tgt_cfg_d = src_cfg;
                    sw_d      = sw_q & src_sw;
                    cnt_d     = DEAD_LD;
                end else begin
                    sw_d   = src_sw;
                    cfg_d  = src_cfg;
                    done_d = 1'b1;
                end
            end
        end else if (bus_commit) begin
            pend_d     = 1'b1;
            pend_sw_d  = bus_sw;
            pend_cfg_d = bus_cfg;
        end
        case (state)
            DEAD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_last) begin
                    sw_d  = tgt_sw_q;
                    cfg_d = tgt_cfg_q;
                    if (SETTLE_CYCLES == 0) done_d = 1'b1;
                    else                    cnt_d  = SETTLE_LD;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_last) done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            sw_q       <= '0;
            cfg_q      <= CFG_RESET;
            tgt_sw_q   <= '0;
            tgt_cfg_q  <= '0;
            pend_q     <= 1'b0;
            pend_sw_q  <= '0;
            pend_cfg_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            mgmt_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sw_q       <= sw_d;
            cfg_q      <= cfg_d;
            tgt_sw_q   <= tgt_sw_d;
            tgt_cfg_q  <= tgt_cfg_d;
            pend_q     <= pend_d;
            pend_sw_q  <= pend_sw_d;
            pend_cfg_q <= pend_cfg_d;
            done_q     <= done_d;
            busy_q     <= (state_next != IDLE);
            mgmt_q     <= mgmt_select;
        end
    end

    assign sw_out          = sw_q;
    assign bus_sw_rb       = sw_q;
    assign cfg_out         = cfg_q;
    assign bus_busy        = busy_q;
    assign bus_pending     = pend_q;
    assign bus_done        = done_q;
    assign bus_mgmt_select = mgmt_q;

endmodule

// File: tb/tb_regs_system_seq.sv
// Bench for regs_system_seq: two builds (SETTLE 8 and 0) checked against a
// timeline model every cycle, plus directed sequences from the test plan.
module tb_regs_system_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] bus_sw = '0;
    logic [34:0] bus_cfg = '0;
    logic        bus_commit = 1'b0;
    logic        bus_seq_en = 1'b1;
    logic        mgmt_select = 1'b0;

    logic        busy0, pend0, done0, mg0, busy1, pend1, done1, mg1;
    logic [23:0] sw0, rb0, sw1, rb1;
    logic [34:0] cfg0, cfg1;

    always #5 clk = ~clk;

    regs_system_seq #(.NUM_SW(24), .CFG_W(35), .DEAD_CYCLES(4), .SETTLE_CYCLES(8)) dut0 (
        .clk(clk), .rst(rst), .bus_sw(bus_sw), .bus_cfg(bus_cfg), .bus_commit(bus_commit),
        .bus_seq_en(bus_seq_en), .bus_busy(busy0), .bus_pending(pend0), .bus_done(done0),
        .bus_sw_rb(rb0), .mgmt_select(mgmt_select), .bus_mgmt_select(mg0),
        .sw_out(sw0), .cfg_out(cfg0));

    regs_system_seq #(.NUM_SW(24), .CFG_W(35), .DEAD_CYCLES(4), .SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .bus_sw(bus_sw), .bus_cfg(bus_cfg), .bus_commit(bus_commit),
        .bus_seq_en(bus_seq_en), .bus_busy(busy1), .bus_pending(pend1), .bus_done(done1),
        .bus_sw_rb(rb1), .mgmt_select(mgmt_select), .bus_mgmt_select(mg1),
        .sw_out(sw1), .cfg_out(cfg1));

    typedef struct {
        logic        active;
        int          s;
        logic [23:0] sw, tgt_sw, psw;
        logic [34:0] cfg, tgt_cfg, pcfg;
        logic        pend, done;
    } mdl_t;

    typedef struct {
        logic        commit;
        logic [23:0] sw;
        logic [34:0] cfg;
        logic [23:0] exp_sw;
        logic [34:0] exp_cfg;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    mdl_t m [2];
    int   dead_c [2];
    int   settle_c [2];
    logic exp_mg;
    int   k = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sequence position is measured in edges since the start edge.
    task automatic model_step(input int i);
        int          e;
        logic [23:0] nsw;
        logic [34:0] ncfg;
        if (rst) begin
            m[i].active = 1'b0; m[i].s = 0; m[i].sw = '0; m[i].cfg = '0;
            m[i].tgt_sw = '0; m[i].tgt_cfg = '0; m[i].psw = '0; m[i].pcfg = '0;
            m[i].pend = 1'b0; m[i].done = 1'b0;
        end else begin
            m[i].done = 1'b0;
            if (!m[i].active) begin
                if (bus_commit || m[i].pend) begin
                    nsw  = bus_commit ? bus_sw  : m[i].psw;
                    ncfg = bus_commit ? bus_cfg : m[i].pcfg;
                    m[i].pend = 1'b0;
                    if (bus_seq_en) begin
                        m[i].active = 1'b1; m[i].s = k;
                        m[i].tgt_sw = nsw; m[i].tgt_cfg = ncfg;
                        m[i].sw = m[i].sw & nsw;
                    end else begin
                        m[i].sw = nsw; m[i].cfg = ncfg; m[i].done = 1'b1;
                    end
                end
            end else begin
                if (bus_commit) begin
                    m[i].pend = 1'b1; m[i].psw = bus_sw; m[i].pcfg = bus_cfg;
                end
                e = k - m[i].s;
                if (e >= dead_c[i]) begin
                    m[i].sw = m[i].tgt_sw; m[i].cfg = m[i].tgt_cfg;
                end
                if (e == dead_c[i] + settle_c[i]) begin
                    m[i].done = 1'b1; m[i].active = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        exp_mg = rst ? 1'b0 : mgmt_select;
        k++;
        @(posedge clk);
        #1;
        check("d0 sw_out",   64'(sw0),   64'(m[0].sw));
        check("d0 sw_rb",    64'(rb0),   64'(m[0].sw));
        check("d0 cfg_out",  64'(cfg0),  64'(m[0].cfg));
        check("d0 busy",     64'(busy0), 64'(m[0].active));
        check("d0 pending",  64'(pend0), 64'(m[0].pend));
        check("d0 done",     64'(done0), 64'(m[0].done));
        check("d0 mgmt",     64'(mg0),   64'(exp_mg));
        check("d1 sw_out",   64'(sw1),   64'(m[1].sw));
        check("d1 sw_rb",    64'(rb1),   64'(m[1].sw));
        check("d1 cfg_out",  64'(cfg1),  64'(m[1].cfg));
        check("d1 busy",     64'(busy1), 64'(m[1].active));
        check("d1 pending",  64'(pend1), 64'(m[1].pend));
        check("d1 done",     64'(done1), 64'(m[1].done));
        check("d1 mgmt",     64'(mg1),   64'(exp_mg));
    endtask

    vec_t vecs [14];

    initial begin
        logic found, seen11;
        int   ndone;
        dead_c[0] = 4; dead_c[1] = 4;
        settle_c[0] = 8; settle_c[1] = 0;

        for (int r = 0; r < 14; r++) begin
            vecs[r].commit   = (r == 0);
            vecs[r].sw       = 24'h0000F0;
            vecs[r].cfg      = 35'h1_2345_6789;
            vecs[r].exp_sw   = (r + 1 <= 4) ? 24'h000000 : 24'h0000F0;
            vecs[r].exp_cfg  = (r + 1 <= 4) ? 35'h0 : 35'h1_2345_6789;
            vecs[r].exp_busy = (r + 1 <= 12);
            vecs[r].exp_done = (r + 1 == 13);
        end

        // reset
        rst = 1'b1;
        tick(); tick();
        check("reset sw_out", 64'(sw0), 64'h0);
        check("reset cfg_out", 64'(cfg0), 64'h0);
        check("reset busy/pend/done", 64'({busy0, pend0, done0}), 64'h0);
        rst = 1'b0;
        tick();

        // preload old switch state 0x00000F immediately
        bus_seq_en = 1'b0; bus_commit = 1'b1; bus_sw = 24'h00000F; bus_cfg = '0;
        tick();
        bus_commit = 1'b0;
        tick();
        check("preload sw", 64'(sw0), 64'h00000F);

        // sequenced commit table
        bus_seq_en = 1'b1;
        for (int r = 0; r < 14; r++) begin
            bus_commit = vecs[r].commit; bus_sw = vecs[r].sw; bus_cfg = vecs[r].cfg;
            tick();
            check($sformatf("seq sw N+%0d", r + 1),   64'(sw0),   64'(vecs[r].exp_sw));
            check($sformatf("seq cfg N+%0d", r + 1),  64'(cfg0),  64'(vecs[r].exp_cfg));
            check($sformatf("seq busy N+%0d", r + 1), 64'(busy0), 64'(vecs[r].exp_busy));
            check($sformatf("seq done N+%0d", r + 1), 64'(done0), 64'(vecs[r].exp_done));
            check($sformatf("settle0 done N+%0d", r + 1), 64'(done1), 64'(r + 1 == 5));
            if (r + 1 == 5) check("settle0 sw at done", 64'(sw1), 64'h0000F0);
        end
        bus_commit = 1'b0;

        // overlapping switches 0x3 -> 0x6
        bus_seq_en = 1'b0; bus_commit = 1'b1; bus_sw = 24'h000003;
        tick();
        bus_commit = 1'b0;
        tick();
        bus_seq_en = 1'b1; bus_commit = 1'b1; bus_sw = 24'h000006;
        for (int c = 1; c <= 14; c++) begin
            tick();
            bus_commit = 1'b0;
            check($sformatf("overlap bit1 N+%0d", c), 64'(sw0[1]), 64'h1);
            if (sw0 == 24'h000007) check("overlap never 7", 64'(sw0), 64'h0);
            if (c == 1) check("overlap bit0 drop", 64'(sw0), 64'h000002);
            if (c == 4) check("overlap bit2 still open", 64'(sw0[2]), 64'h0);
            if (c == 5) check("overlap bit2 rise", 64'(sw0), 64'h000006);
        end

        // immediate mode
        bus_seq_en = 1'b0; bus_commit = 1'b1; bus_sw = 24'hABCDEF;
        tick();
        bus_commit = 1'b0;
        check("imm sw", 64'(sw0), 64'hABCDEF);
        check("imm done", 64'(done0), 64'h1);
        check("imm busy", 64'(busy0), 64'h0);
        tick();
        check("imm busy after", 64'(busy0), 64'h0);
        check("imm done after", 64'(done0), 64'h0);

        // queued commits
        bus_seq_en = 1'b1; bus_commit = 1'b1; bus_sw = 24'h000001; bus_cfg = 35'h5;
        tick();
        bus_sw = 24'h000011;
        tick();
        bus_sw = 24'h000022;
        tick();
        bus_commit = 1'b0; bus_sw = '0;
        check("queue pending", 64'(pend0), 64'h1);
        found = 1'b0; seen11 = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (sw0 == 24'h000011) seen11 = 1'b1;
            if (done0) found = 1'b1;
        end
        check("queue first done seen", 64'(found), 64'h1);
        check("queue done cycle busy", 64'(busy0), 64'h0);
        check("queue done cycle pending", 64'(pend0), 64'h1);
        check("queue first target", 64'(sw0), 64'h000001);
        tick();
        check("queue restart busy", 64'(busy0), 64'h1);
        check("queue restart pending", 64'(pend0), 64'h0);
        check("queue restart break", 64'(sw0), 64'h000000);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (sw0 == 24'h000011) seen11 = 1'b1;
            if (done0) found = 1'b1;
        end
        check("queue second done seen", 64'(found), 64'h1);
        check("queue final sw", 64'(sw0), 64'h000022);
        check("queue 0x11 never applied", 64'(seen11), 64'h0);

        // reset mid-DEAD with a queued commit
        bus_commit = 1'b1; bus_sw = 24'h0000FF; bus_cfg = 35'h7;
        tick();
        bus_sw = 24'h000033;
        tick();
        bus_commit = 1'b0;
        check("rst pre pending", 64'(pend0), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst sw", 64'(sw0), 64'h0);
        check("rst cfg", 64'(cfg0), 64'h0);
        check("rst busy/pend/done", 64'({busy0, pend0, done0}), 64'h0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done0) ndone++;
        end
        check("rst no later done", 64'(ndone), 64'h0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 199) == 0);
            bus_commit  = ($urandom_range(0, 7) == 0);
            bus_seq_en  = ($urandom_range(0, 3) != 0);
            bus_sw      = 24'($urandom());
            bus_cfg     = 35'({$urandom(), $urandom()});
            mgmt_select = 1'($urandom());
            tick();
        end
        rst = 1'b0; bus_commit = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
